rally_flow_ctrl: RTL and testbench

//  Game-flow sequencer for the volleyball datapath. Drives Game_state/who_win into the

---
 rtl/rally_flow_ctrl.sv | 141 ++++++++++++++
 tb/tb_rally_flow_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rally_flow_ctrl.sv
// Game-flow sequencer for the volleyball datapath: serve timing, ground-contact
// scoring, score keeping and match end, all registered on clk.
module rally_flow_ctrl #(
  parameter int unsigned WIN_SCORE    = 15,
  parameter int unsigned SERVE_CYCLES = 50_000_000,
  parameter int unsigned END_HOLD     = 100_000_000,
  parameter int unsigned GROUND_Y     = 220,
  parameter int unsigned BALL_W       = 30,
  parameter int unsigned BALL_H       = 30,
  parameter int unsigned NET_X        = 160,
  parameter int unsigned NET_W        = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  player_score,
  output logic [3:0]  npc_score,
  output logic        point_pulse,
  output logic        match_winner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic [12:0] GROUND_LIM = 13'(GROUND_Y);
  localparam logic [12:0] BALL_H13   = 13'(BALL_H);
  localparam logic [12:0] BALL_HALF  = 13'(BALL_W / 2);
  localparam logic [12:0] NET_CTR    = 13'(NET_X + NET_W / 2);
  localparam logic [31:0] SERVE_LAST = 32'(SERVE_CYCLES - 1);
  localparam logic [31:0] END_LAST   = 32'(END_HOLD - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic [3:0]  player_nxt, npc_nxt, npc_inc, player_inc;
  logic        who_nxt, pulse_nxt, winner_nxt;
  logic [12:0] ball_bottom, ball_cx;
  logic        ground, npc_scores;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  // 13-bit arithmetic so the ball position plus its size can never wrap
  assign ball_bottom = {1'b0, Ball_Y} + BALL_H13;
  assign ball_cx     = {1'b0, Ball_X} + BALL_HALF;
  assign ground      = (ball_bottom >= GROUND_Y_CMP());
  assign npc_scores  = (ball_cx >= NET_CTR);
  assign player_inc  = score_inc(player_score);
  assign npc_inc     = score_inc(npc_score);

  function automatic logic [12:0] GROUND_Y_CMP();
    return GROUND_LIM;
  endfunction

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    player_nxt = player_score;
    npc_nxt    = npc_score;
    who_nxt    = who_win;
    pulse_nxt  = 1'b0;
    winner_nxt = match_winner;
    case (state)
      ST_IDLE: begin
        if (start_btn) begin
          state_nxt  = ST_SERVE;
          player_nxt = 4'd0;
          npc_nxt    = 4'd0;
          who_nxt    = 1'b0;
        end
      end
      ST_SERVE: begin
        timer_nxt = sat_inc32(timer);
        if (timer == SERVE_LAST) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (ground) begin
          pulse_nxt = 1'b1;
          who_nxt   = npc_scores;
          if (npc_scores) begin
            npc_nxt = npc_inc;
            state_nxt = (npc_inc == WIN) ? ST_END : ST_SERVE;
          end else begin
            player_nxt = player_inc;
            state_nxt  = (player_inc == WIN) ? ST_END : ST_SERVE;
          end
          if (state_nxt == ST_END) winner_nxt = npc_scores;
        end
      end
      ST_END: begin
        timer_nxt = sat_inc32(timer);
        // presses before the hold expires are dropped, not remembered
        if (start_btn && (timer >= END_LAST)) begin
          state_nxt  = ST_SERVE;
          player_nxt = 4'd0;
          npc_nxt    = 4'd0;
          who_nxt    = match_winner;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state) timer_nxt = 32'd0;
  end

  // ---- register stage: all outputs come straight from flops ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      timer        <= 32'd0;
      player_score <= 4'd0;
      npc_score    <= 4'd0;
      who_win      <= 1'b0;
      point_pulse  <= 1'b0;
      match_winner <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      player_score <= player_nxt;
      npc_score    <= npc_nxt;
      who_win      <= who_nxt;
      point_pulse  <= pulse_nxt;
      match_winner <= winner_nxt;
    end
  end

  assign Game_state = state;

endmodule

// File: tb/tb_rally_flow_ctrl.sv
// Directed bench for rally_flow_ctrl with SERVE_CYCLES=4, END_HOLD=5, WIN_SCORE=3.
module tb_rally_flow_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_btn = 1'b0;
  logic [11:0] Ball_X = 12'd0;
  logic [11:0] Ball_Y = 12'd0;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  player_score;
  logic [3:0]  npc_score;
  logic        point_pulse;
  logic        match_winner;

  int checks = 0;
  int fails  = 0;

  // {state, player, npc, who_win, point_pulse, match_winner}
  wire [12:0] obs = {Game_state, player_score, npc_score, who_win, point_pulse, match_winner};

  rally_flow_ctrl #(
    .WIN_SCORE(3), .SERVE_CYCLES(4), .END_HOLD(5),
    .GROUND_Y(220), .BALL_W(30), .BALL_H(30), .NET_X(160), .NET_W(6)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn),
    .Ball_X(Ball_X), .Ball_Y(Ball_Y),
    .Game_state(Game_state), .who_win(who_win),
    .player_score(player_score), .npc_score(npc_score),
    .point_pulse(point_pulse), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ball();
    Ball_X = 12'd0;
    Ball_Y = 12'd0;
  endtask

  task automatic wait_play();
    for (int i = 0; i < 20 && Game_state !== 2'd2; i++) tick();
    checks++;
    if (Game_state !== 2'd2) begin
      fails++;
      $display("FAIL wait_play: state %0d, required 2", Game_state);
    end
  endtask

  task automatic test_reset();
    logic [12:0] want;
    reset = 1'b1;
    tick();
    tick();
    want = {2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL reset_state: got %b required %b", obs, want);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL idle_hold: got %b required %b", obs, want);
    end
  endtask

  task automatic test_serve_timing();
    logic [12:0] want;
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    want = {2'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL serve_cycle%0d: got %b required %b", i, obs, want);
      end
      start_btn = (i == 1);
      tick();
      start_btn = 1'b0;
    end
    checks++;
    if (Game_state !== 2'd2) begin
      fails++;
      $display("FAIL serve_to_play: state %0d required 2", Game_state);
    end
  endtask

  task automatic test_points();
    logic [12:0] want;
    Ball_X = 12'd40;
    Ball_Y = 12'd190;
    tick();
    want = {2'd1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL player_point: got %b required %b", obs, want);
    end
    // ground stays asserted while serving: no score, pulse already gone
    for (int i = 0; i < 2; i++) begin
      tick();
      want = {2'd1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL serve_ignores_ground%0d: got %b required %b", i, obs, want);
      end
    end
    clear_ball();
    wait_play();
    Ball_X = 12'd200;
    Ball_Y = 12'd195;
    tick();
    clear_ball();
    want = {2'd1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL npc_point: got %b required %b", obs, want);
    end
  endtask

  task automatic test_centre_tie();
    logic [12:0] want;
    wait_play();
    Ball_X = 12'd148;
    Ball_Y = 12'd190;
    tick();
    clear_ball();
    want = {2'd1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL centre_tie: got %b required %b", obs, want);
    end
  endtask

  task automatic test_single_point();
    logic [12:0] want;
    wait_play();
    Ball_X = 12'd147;
    Ball_Y = 12'd190;
    tick();
    want = {2'd1, 4'd2, 4'd2, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL left_of_centre: got %b required %b", obs, want);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({player_score, npc_score, point_pulse} !== {4'd2, 4'd2, 1'b0}) begin
        fails++;
        $display("FAIL held_contact%0d: got %0d/%0d/%0d required 2/2/0",
                 i, player_score, npc_score, point_pulse);
      end
    end
    Ball_X = 12'd40;
    Ball_Y = 12'd189;
    tick();
    want = {2'd2, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL above_ground: got %b required %b", obs, want);
    end
    clear_ball();
  endtask

  task automatic test_match_end();
    logic [12:0] want;
    wait_play();
    Ball_X = 12'd40;
    Ball_Y = 12'd190;
    tick();
    want = {2'd3, 4'd3, 4'd2, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL player_wins: got %b required %b", obs, want);
    end
    tick();
    tick();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    want = {2'd3, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL early_start: got %b required %b", obs, want);
    end
    tick();
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL end_frozen: got %b required %b", obs, want);
    end
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    clear_ball();
    want = {2'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL restart: got %b required %b", obs, want);
    end
  endtask

  task automatic test_npc_match();
    logic [12:0] want;
    for (int k = 1; k <= 3; k++) begin
      wait_play();
      Ball_X = 12'd200;
      Ball_Y = 12'd195;
      tick();
      clear_ball();
      want = (k == 3) ? {2'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b1}
                      : {2'd1, 4'd0, 4'(k), 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL npc_run%0d: got %b required %b", k, obs, want);
      end
    end
    for (int i = 0; i < 4; i++) tick();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    checks++;
    if ({Game_state, player_score, npc_score, who_win} !== {2'd1, 4'd0, 4'd0, 1'b1}) begin
      fails++;
      $display("FAIL winner_serves: got %b required %b",
               {Game_state, player_score, npc_score, who_win}, {2'd1, 4'd0, 4'd0, 1'b1});
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] want;
    want = {2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    wait_play();
    Ball_X = 12'd40;
    Ball_Y = 12'd190;
    tick();
    clear_ball();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL reset_in_serve: got %b required %b", obs, want);
    end
    #2;
    reset = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_play();
      Ball_X = 12'd200;
      Ball_Y = 12'd195;
      tick();
      clear_ball();
    end
    checks++;
    if ({Game_state, match_winner} !== {2'd3, 1'b1}) begin
      fails++;
      $display("FAIL reach_end: got %b required %b", {Game_state, match_winner}, {2'd3, 1'b1});
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL reset_in_end: got %b required %b", obs, want);
    end
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (obs !== want) begin
      fails++;
      $display("FAIL idle_after_reset: got %b required %b", obs, want);
    end
  endtask

  initial begin
    test_reset();
    test_serve_timing();
    test_points();
    test_centre_tie();
    test_single_point();
    test_match_end();
    test_npc_match();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
